// File: rtl/game_undo_stack.sv
// Move-history LIFO with a reverse-move engine for the Sokoban core.
// Each pushed move can be undone; the block returns the game state from before that move.
module game_undo_stack #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push_valid,
    input  logic [1:0]       push_dir,
    input  logic             push_box,
    input  logic             undo_req,
    input  logic [133:0]     game_state,
    output logic [133:0]     game_state_prev,
    output logic             undo_valid,
    output logic             undo_fail,
    output logic             busy,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic       box;
        logic [1:0] dir;
    } rec_t;

    typedef enum logic [1:0] {IDLE, FETCH, APPLY} state_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    rec_t               mem [DEPTH];
    rec_t               rec_rd;
    logic [PTR_W-1:0]   wr_ptr;
    state_t             state, state_nxt;
    logic               do_push, undo_acc, start_undo, fail_nxt;

    logic [63:0]        way_in, box_in, way_rev, box_rev;
    logic [2:0]         mx, my, px, py, fx, fy;
    logic [5:0]         m_idx, f_idx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; clear aborts anything in flight
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_undo) state_nxt = FETCH;
                FETCH:   state_nxt = APPLY;
                APPLY:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output / control decode; a push in the same cycle as an undo request wins
    always_comb begin
        busy       = (state != IDLE);
        do_push    = !clear && (state == IDLE) && push_valid;
        undo_acc   = !clear && (state == IDLE) && undo_req && !push_valid;
        start_undo = undo_acc && (count != '0);
        fail_nxt   = undo_acc && (count == '0);
    end

    // Reverse move: man steps back against dir; a pushed box is pulled back onto the man's cell
    always_comb begin
        rec_rd = mem[wr_ptr - PTR_W'(1)];
        way_in = game_state[133:70];
        box_in = game_state[69:6];
        my     = game_state[5:3];
        mx     = game_state[2:0];
        px = mx; py = my; fx = mx; fy = my;
        case (rec_rd.dir)
            2'd0: begin px = mx - 3'd1; fx = mx + 3'd1; end
            2'd1: begin px = mx + 3'd1; fx = mx - 3'd1; end
            2'd2: begin py = my - 3'd1; fy = my + 3'd1; end
            default: begin py = my + 3'd1; fy = my - 3'd1; end
        endcase
        m_idx   = {my, mx};
        f_idx   = {fy, fx};
        way_rev = way_in;
        box_rev = box_in;
        if (rec_rd.box) begin
            box_rev[f_idx] = 1'b0;
            box_rev[m_idx] = 1'b1;
            way_rev[f_idx] = 1'b1;
            way_rev[m_idx] = 1'b0;
        end
    end

    // Record storage carries no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{box: push_box, dir: push_dir};
    end

    // The result is registered at the end of FETCH so undo_valid lands two cycles after
    // acceptance; APPLY keeps busy high while the controller writes the state back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            count           <= '0;
            undo_valid      <= 1'b0;
            undo_fail       <= 1'b0;
            game_state_prev <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            count      <= '0;
            undo_valid <= 1'b0;
            undo_fail  <= 1'b0;
        end else begin
            undo_valid <= 1'b0;
            undo_fail  <= fail_nxt;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (count != FULL) count <= count + (PTR_W+1)'(1);
            end
            if (state == FETCH) begin
                game_state_prev <= {way_rev, box_rev, py, px};
                undo_valid      <= 1'b1;
                wr_ptr          <= wr_ptr - PTR_W'(1);
                count           <= count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_game_undo_stack.sv
// Bench for game_undo_stack: directed vector table, hand sequences for corner cases,
// and random push/undo/clear traffic against a queue-based history model.
module tb_game_undo_stack;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic           clk = 1'b0;
    logic           rst_n, clear, push_valid, push_box, undo_req;
    logic [1:0]     push_dir;
    logic [133:0]   game_state, game_state_prev;
    logic           undo_valid, undo_fail, busy;
    logic [PTR_W:0] count;

    int total = 0;
    int bad   = 0;
    int hist[$];

    typedef struct {
        int           dir;
        bit           bx;
        logic [133:0] gs;
        logic [133:0] exp;
    } vec_t;

    vec_t tbl[5];

    game_undo_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .push_valid      (push_valid),
        .push_dir        (push_dir),
        .push_box        (push_box),
        .undo_req        (undo_req),
        .game_state      (game_state),
        .game_state_prev (game_state_prev),
        .undo_valid      (undo_valid),
        .undo_fail       (undo_fail),
        .busy            (busy),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_gs(string name, logic [133:0] act, logic [133:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [133:0] mk_gs(int x, int y, logic [63:0] w, logic [63:0] b);
        return {w, b, 3'(y), 3'(x)};
    endfunction

    function automatic logic [133:0] rnd_gs();
        return mk_gs(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                     {$urandom, $urandom}, {$urandom, $urandom});
    endfunction

    // Undo of one move from plain grid arithmetic: index = y*8 + x
    function automatic logic [133:0] ref_undo(logic [133:0] gs, int dir, bit bx);
        int x, y, dx, dy, m, f;
        logic [63:0] w, b;
        w  = gs[133:70];
        b  = gs[69:6];
        x  = int'(gs[2:0]);
        y  = int'(gs[5:3]);
        dx = (dir == 0) ? 1 : (dir == 1) ? -1 : 0;
        dy = (dir == 2) ? 1 : (dir == 3) ? -1 : 0;
        m  = y * 8 + x;
        f  = (y + dy) * 8 + (x + dx);
        if (bx) begin
            b[f] = 1'b0; b[m] = 1'b1;
            w[f] = 1'b1; w[m] = 1'b0;
        end
        return mk_gs(x - dx, y - dy, w, b);
    endfunction

    task automatic do_push(int dir, bit bx);
        push_valid = 1'b1;
        push_dir   = 2'(dir);
        push_box   = bx;
        step();
        push_valid = 1'b0;
        hist.push_back(int'(bx) * 4 + dir);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        chk("push_count", int'(count), hist.size());
    endtask

    // Undo request in cycle N; checks N+1, N+2 (result) and N+3
    task automatic do_undo(string tag, logic [133:0] gs, bit ok, logic [133:0] exp, int cnt_after);
        game_state = gs;
        undo_req   = 1'b1;
        step();
        undo_req = 1'b0;
        if (!ok) begin
            chk({tag, "_fail"}, int'(undo_fail), 1);
            chk({tag, "_busy_n1"}, int'(busy), 0);
            chk({tag, "_valid_n1"}, int'(undo_valid), 0);
            chk({tag, "_count"}, int'(count), 0);
            step();
            chk({tag, "_fail_n2"}, int'(undo_fail), 0);
            chk({tag, "_busy_n2"}, int'(busy), 0);
        end else begin
            chk({tag, "_busy_n1"}, int'(busy), 1);
            chk({tag, "_valid_n1"}, int'(undo_valid), 0);
            step();
            chk({tag, "_valid_n2"}, int'(undo_valid), 1);
            chk({tag, "_fail_n2"}, int'(undo_fail), 0);
            chk({tag, "_busy_n2"}, int'(busy), 1);
            chk_gs({tag, "_prev"}, game_state_prev, exp);
            chk({tag, "_count"}, int'(count), cnt_after);
            step();
            chk({tag, "_valid_n3"}, int'(undo_valid), 0);
            chk({tag, "_busy_n3"}, int'(busy), 0);
            chk_gs({tag, "_hold"}, game_state_prev, exp);
        end
    endtask

    task automatic model_undo(string tag);
        int r;
        logic [133:0] gs, exp;
        gs = rnd_gs();
        if (hist.size() == 0) begin
            do_undo(tag, gs, 1'b0, '0, 0);
        end else begin
            r   = hist.pop_back();
            exp = ref_undo(gs, r % 4, r / 4 == 1);
            do_undo(tag, gs, 1'b1, exp, hist.size());
        end
    endtask

    initial begin
        logic [133:0] gs, exp;
        int r;

        tbl[0] = '{0, 1'b1, mk_gs(3, 3, 64'h0800_0000, 64'h1000_0000),
                            mk_gs(2, 3, 64'h1000_0000, 64'h0800_0000)};
        tbl[1] = '{2, 1'b0, mk_gs(3, 4, 64'hFFFF, 64'h1234),
                            mk_gs(3, 3, 64'hFFFF, 64'h1234)};
        tbl[2] = '{1, 1'b1, mk_gs(4, 2, 64'hF000_0000_0010_0000, 64'h8_0000),
                            mk_gs(5, 2, 64'hF000_0000_0008_0000, 64'h10_0000)};
        tbl[3] = '{3, 1'b1, mk_gs(6, 5, 64'h4000_0000_0000, 64'h40_0000_0000),
                            mk_gs(6, 6, 64'h40_0000_0000, 64'h4000_0000_0000)};
        tbl[4] = '{2, 1'b1, mk_gs(1, 1, 64'h200, 64'h2_0000),
                            mk_gs(1, 0, 64'h2_0000, 64'h200)};

        rst_n = 1'b0; clear = 1'b0; push_valid = 1'b0; push_box = 1'b0;
        push_dir = 2'd0; undo_req = 1'b0; game_state = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(undo_valid), 0);
        chk("rst_fail", int'(undo_fail), 0);
        chk_gs("rst_prev", game_state_prev, '0);

        do_undo("empty", rnd_gs(), 1'b0, '0, 0);

        for (int i = 0; i < 5; i++) begin
            do_push(tbl[i].dir, tbl[i].bx);
            void'(hist.pop_back());
            do_undo($sformatf("vec%0d", i), tbl[i].gs, 1'b1, tbl[i].exp, 0);
        end

        // Overflow: 17 pushes keep the newest 16
        for (int i = 0; i < 17; i++) do_push(i % 4, ((i / 4) % 2) == 1);
        chk("full_count", int'(count), DEPTH);
        for (int i = 0; i < 16; i++) model_undo("drain");
        do_undo("drain_empty", rnd_gs(), 1'b0, '0, 0);

        // Push and undo together: push wins, no response
        push_valid = 1'b1; push_dir = 2'd1; push_box = 1'b0; undo_req = 1'b1;
        step();
        push_valid = 1'b0; undo_req = 1'b0;
        hist.push_back(1);
        chk("both_count", int'(count), 1);
        chk("both_valid", int'(undo_valid), 0);
        chk("both_fail", int'(undo_fail), 0);
        step();
        chk("both_valid2", int'(undo_valid), 0);
        chk("both_busy", int'(busy), 0);

        // Push while busy is ignored
        gs = rnd_gs();
        r = hist.pop_back();
        exp = ref_undo(gs, r % 4, r / 4 == 1);
        game_state = gs; undo_req = 1'b1;
        step();
        undo_req = 1'b0; push_valid = 1'b1; push_dir = 2'd3; push_box = 1'b1;
        step();
        push_valid = 1'b0;
        chk("bpush_valid", int'(undo_valid), 1);
        chk_gs("bpush_prev", game_state_prev, exp);
        step();
        chk("bpush_count", int'(count), 0);
        chk("bpush_busy", int'(busy), 0);

        // Clear during FETCH aborts the undo
        do_push(0, 1'b0);
        game_state = rnd_gs(); undo_req = 1'b1;
        step();
        undo_req = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        hist.delete();
        chk("clr_valid", int'(undo_valid), 0);
        chk("clr_count", int'(count), 0);
        chk("clr_busy", int'(busy), 0);
        step();
        chk("clr_valid2", int'(undo_valid), 0);

        // Reset in the APPLY cycle clears outputs immediately
        do_push(2, 1'b1);
        game_state = mk_gs(3, 3, 64'h0, 64'h0); undo_req = 1'b1;
        step();
        undo_req = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(undo_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_fail", int'(undo_fail), 0);
        chk_gs("arst_prev", game_state_prev, '0);
        step();
        rst_n = 1'b1;
        hist.delete();
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
                hist.delete();
                chk("rnd_clear", int'(count), 0);
            end else if (r < 11) begin
                do_push(int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            end else begin
                model_undo("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
